// File: rtl/bitsend.sv
// Host-to-keyboard PS/2 command transmitter: inhibits the bus, issues a start
// bit, shifts an odd-parity frame on device clock edges and collects the ack.
module bitsend #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       kbd_clk,
    input  logic       kbd_dat,
    output logic       kbd_clk_oe,
    output logic       kbd_dat_oe,
    output logic       ready,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, SEND, WAIT_ACK, WAIT_IDLE, FINISH
    } state_t;

    state_t           state, state_n;
    logic             kclk_p0, kclk_p1, kclk_p2;
    logic             kdat_p0, kdat_p1;
    logic [INH_W-1:0] inh_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic [3:0]       edge_cnt;
    logic [9:0]       sreg;
    logic             dat_oe_r;
    logic             ack_r;
    logic             to_flag;
    logic             fall_edge, any_edge, wd_expire, line_active;

    // Pad synchronizers: p1 is the synchronized level, p2 its previous value
    assign fall_edge   = kclk_p2 & ~kclk_p1;
    assign any_edge    = kclk_p2 ^ kclk_p1;
    assign line_active = (state == SEND) || (state == WAIT_ACK) || (state == WAIT_IDLE);
    assign wd_expire   = line_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (din_valid) state_n = INHIBIT;
            INHIBIT:   if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) state_n = START;
            START:     state_n = SEND;
            SEND:      if (fall_edge && edge_cnt == 4'd9) state_n = WAIT_ACK;
            WAIT_ACK:  if (fall_edge) state_n = WAIT_IDLE;
            WAIT_IDLE: if (kclk_p1 && kdat_p1) state_n = FINISH;
            FINISH:    state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        if (wd_expire) state_n = FINISH;
    end

    assign ready      = (state == IDLE);
    assign kbd_clk_oe = (state == INHIBIT) || (state == START);
    assign kbd_dat_oe = dat_oe_r;
    assign done       = (state == FINISH);
    assign timeout    = done & to_flag;
    assign ack_ok     = done & ack_r & ~to_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            kclk_p0  <= 1'b1;
            kclk_p1  <= 1'b1;
            kclk_p2  <= 1'b1;
            kdat_p0  <= 1'b1;
            kdat_p1  <= 1'b1;
            inh_cnt  <= '0;
            wd_cnt   <= '0;
            edge_cnt <= '0;
            sreg     <= '0;
            dat_oe_r <= 1'b0;
            ack_r    <= 1'b0;
            to_flag  <= 1'b0;
        end else begin
            kclk_p0 <= kbd_clk;
            kclk_p1 <= kclk_p0;
            kclk_p2 <= kclk_p1;
            kdat_p0 <= kbd_dat;
            kdat_p1 <= kdat_p0;
            state   <= state_n;

            // Watchdog restarts on any clock-line activity and on every state change
            if (state_n != state || any_edge)
                wd_cnt <= '0;
            else if (wd_cnt != WD_W'(TIMEOUT_CYCLES))
                wd_cnt <= wd_cnt + 1'b1;

            case (state)
                IDLE: begin
                    dat_oe_r <= 1'b0;
                    if (din_valid) begin
                        sreg     <= {1'b1, ~^din, din};
                        inh_cnt  <= '0;
                        edge_cnt <= '0;
                        ack_r    <= 1'b0;
                        to_flag  <= 1'b0;
                    end
                end
                INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    if (state_n == START) dat_oe_r <= 1'b1;
                end
                SEND: begin
                    // Data only moves while the device holds the clock low
                    if (fall_edge) begin
                        dat_oe_r <= ~sreg[0];
                        sreg     <= {1'b0, sreg[9:1]};
                        edge_cnt <= edge_cnt + 4'd1;
                    end
                end
                WAIT_ACK: begin
                    if (fall_edge) ack_r <= ~kdat_p1;
                end
                FINISH: dat_oe_r <= 1'b0;
                default: ;
            endcase

            if (wd_expire) begin
                dat_oe_r <= 1'b0;
                to_flag  <= 1'b1;
            end
        end
    end

endmodule
